// File: rtl/cfg_apb_sequencer_if.sv
// APB slave bus bundle for cfg_apb_sequencer.
// Zero-wait-state APB: PREADY is driven high by the slave at all times.
// `DWIDTH (normalization constant width) defaults to 16 when not defined globally.

`ifndef DWIDTH
`define DWIDTH 16
`endif

interface cfg_apb_sequencer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );
endinterface

// File: rtl/cfg_apb_sequencer.sv
// Register-programmed configuration and run sequencer for the accelerator
// datapath. Software programs stage enables and normalization constants over
// APB, launches a run, and the block holds the configuration stable until the
// datapath reports done. Records status and the run cycle count.
//
// Optional feature macro: CFG_SEQ_TIMEOUT_EN
//   defined   -> TMO_LIMIT register and BUSY watchdog are built
//   undefined -> TMO_LIMIT reads 0, STATUS.TIMEOUT is always 0
//
// State table:
//   state   | meaning
//   IDLE    | no run in progress, enables low, waiting for a launch
//   START   | one-cycle launch; start pulse high, enables valid
//   BUSY    | run in progress; waiting for done, abort or timeout

`ifndef DWIDTH
`define DWIDTH 16
`endif

module cfg_apb_sequencer #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    cfg_apb_sequencer_if.slave apb,
    output logic               start,
    output logic               enable_matmul,
    output logic               enable_norm,
    output logic               enable_activation,
    output logic               enable_pool,
    output logic [`DWIDTH-1:0] mean,
    output logic [`DWIDTH-1:0] inv_var,
    input  logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MEAN    = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INV_VAR = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CYCLES  = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TMO     = ADDR_WIDTH'(8'h14);

    state_t state;
    state_t state_next;

    logic wr_en;
    logic rd_en;
    logic sel_ctrl;
    logic sel_status;
    logic sel_mean;
    logic sel_inv_var;
    logic sel_cycles;
    logic sel_tmo;

    logic               start_wr;
    logic               abort_wr;
    logic               status_wr;
    logic               launch;
    logic               launch_reject;
    logic               finish_done;
    logic               finish_tmo;
    logic               tmo_hit;
    logic               busy;

    logic [3:0]         en_reg;
    logic [`DWIDTH-1:0] mean_reg;
    logic [`DWIDTH-1:0] inv_var_reg;
    logic [3:0]         shadow_en;
    logic [`DWIDTH-1:0] shadow_mean;
    logic [`DWIDTH-1:0] shadow_inv_var;

    logic               st_done;
    logic               st_err;
    logic               st_tmo;
    logic [31:0]        cycles_reg;
    logic [31:0]        run_cnt;
    logic [31:0]        run_cnt_inc;
    logic [31:0]        tmo_limit;
    logic [31:0]        rdata;

    // Not every write-data bit lands in a register for every DWIDTH / build.
    logic unused_pwdata;
    assign unused_pwdata = ^apb.PWDATA;

    assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_en       = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign sel_ctrl    = (apb.PADDR == ADDR_CTRL);
    assign sel_status  = (apb.PADDR == ADDR_STATUS);
    assign sel_mean    = (apb.PADDR == ADDR_MEAN);
    assign sel_inv_var = (apb.PADDR == ADDR_INV_VAR);
    assign sel_cycles  = (apb.PADDR == ADDR_CYCLES);
    assign sel_tmo     = (apb.PADDR == ADDR_TMO);

    // ABORT in the same write masks START completely.
    assign abort_wr  = wr_en & sel_ctrl & apb.PWDATA[8];
    assign start_wr  = wr_en & sel_ctrl & apb.PWDATA[0] & ~apb.PWDATA[8];
    assign status_wr = wr_en & sel_status;

    assign busy        = (state != S_IDLE);
    assign run_cnt_inc = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

`ifdef CFG_SEQ_TIMEOUT_EN
    // Counter is monotonic during a run, so >= behaves as "reaches" and also
    // catches a limit lowered below the current count mid-run.
    assign tmo_hit = (tmo_limit != 32'd0) && (run_cnt >= tmo_limit);
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and launch/finish decode; done beats abort beats timeout.
    always_comb begin
        state_next    = state;
        start         = 1'b0;
        launch        = 1'b0;
        launch_reject = 1'b0;
        finish_done   = 1'b0;
        finish_tmo    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_wr) begin
                    if (apb.PWDATA[4:1] != 4'd0) begin
                        launch     = 1'b1;
                        state_next = S_START;
                    end else begin
                        launch_reject = 1'b1;
                    end
                end
            end
            S_START: begin
                start         = 1'b1;
                launch_reject = start_wr;
                state_next    = S_BUSY;
            end
            S_BUSY: begin
                launch_reject = start_wr;
                if (done) begin
                    finish_done = 1'b1;
                    state_next  = S_IDLE;
                end else if (abort_wr) begin
                    state_next  = S_IDLE;
                end else if (tmo_hit) begin
                    finish_tmo  = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_reg      <= 4'd0;
            mean_reg    <= '0;
            inv_var_reg <= '0;
        end else if (wr_en) begin
            if (sel_ctrl)    en_reg      <= apb.PWDATA[4:1];
            if (sel_mean)    mean_reg    <= apb.PWDATA[`DWIDTH-1:0];
            if (sel_inv_var) inv_var_reg <= apb.PWDATA[`DWIDTH-1:0];
        end
    end

    // Shadow copies drive the datapath; only a launch refreshes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_en      <= 4'd0;
            shadow_mean    <= '0;
            shadow_inv_var <= '0;
        end else if (launch) begin
            shadow_en      <= apb.PWDATA[4:1];
            shadow_mean    <= mean_reg;
            shadow_inv_var <= inv_var_reg;
        end
    end

    // Run counter: cleared at launch, counts START and BUSY cycles, saturates.
    always_ff @(posedge clk) begin
        if (reset)     run_cnt <= 32'd0;
        else if (launch) run_cnt <= 32'd0;
        else if (busy)   run_cnt <= run_cnt_inc;
    end

    // CYCLES includes the done cycle itself.
    always_ff @(posedge clk) begin
        if (reset)            cycles_reg <= 32'd0;
        else if (finish_done) cycles_reg <= run_cnt_inc;
    end

    // Sticky status bits; a hardware set wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
        end else begin
            st_done <= finish_done   | (st_done & ~(status_wr & apb.PWDATA[1]));
            st_err  <= launch_reject | (st_err  & ~(status_wr & apb.PWDATA[2]));
        end
    end

`ifdef CFG_SEQ_TIMEOUT_EN
    // Watchdog limit and timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_limit <= 32'd0;
            st_tmo    <= 1'b0;
        end else begin
            if (wr_en && sel_tmo) tmo_limit <= apb.PWDATA;
            st_tmo <= finish_tmo | (st_tmo & ~(status_wr & apb.PWDATA[3]));
        end
    end
`else
    assign tmo_limit = 32'd0;
    assign st_tmo    = finish_tmo;
`endif

    // Combinational read mux; zero outside a read access phase.
    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            if (sel_ctrl)    rdata = {23'd0, 4'd0, en_reg, 1'b0};
            if (sel_status)  rdata = {28'd0, st_tmo, st_err, st_done, busy};
            if (sel_mean)    rdata = 32'(mean_reg);
            if (sel_inv_var) rdata = 32'(inv_var_reg);
            if (sel_cycles)  rdata = cycles_reg;
            if (sel_tmo)     rdata = tmo_limit;
        end
    end

    assign apb.PRDATA = rdata;
    assign apb.PREADY = 1'b1;

    assign {enable_pool, enable_activation, enable_norm, enable_matmul} =
        busy ? shadow_en : 4'd0;
    assign mean    = shadow_mean;
    assign inv_var = shadow_inv_var;

endmodule

// File: doc/cfg_apb_sequencer.md
# cfg_apb_sequencer

Register-programmed configuration and run sequencer for the accelerator datapath (matmul, norm, activation, pool). Software programs the stage enables and the normalization constants over a zero-wait-state APB slave port and launches a run. The block then drives a one-cycle `start` and holds the enables and constants stable until the datapath returns `done`. It records completion status and run cycle count, and replaces the testbench-forced configuration outputs.

## Interface
- `ADDR_WIDTH`, 8: APB address width, byte addressed; registers are word aligned.
- `` `DWIDTH ``, global define: width of `mean` and `inv_var`.

- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB control.
- `PADDR` in ADDR_WIDTH: APB address.
- `PWDATA` in 32: APB write data.
- `PRDATA` out 32: APB read data.
- `PREADY` out 1: tied 1.
- `start` out 1: one-cycle launch pulse.
- `enable_matmul`, `enable_norm`, `enable_activation`, `enable_pool` out 1: stage enables.
- `mean`, `inv_var` out `` `DWIDTH ``: normalization constants.
- `done` in 1: datapath completion pulse.

## Operation
- Register map (unmapped addresses: read 0, writes ignored):
  - 0x00 CTRL: [0] START (W1, self-clearing, reads 0); [4:1] EN = {pool, act, norm, matmul}; [8] ABORT (W1, reads 0).
  - 0x04 STATUS: [0] BUSY (RO); [1] DONE (W1C); [2] ERR (W1C); [3] TIMEOUT (W1C).
  - 0x08 MEAN and 0x0C INV_VAR: [`DWIDTH-1:0] read/write; upper bits read 0.
  - 0x10 CYCLES: RO, cycle count of the last completed run.
  - 0x14 TMO_LIMIT: read/write; see Configuration.
- A write commits when `PSEL & PENABLE & PWRITE` is high. During `PSEL & PENABLE & !PWRITE`, `PRDATA` returns the register value combinationally; otherwise `PRDATA` is 0.
- FSM states are IDLE, START, BUSY.
  - IDLE → START: START written with EN ≠ 0. On this transition, EN, MEAN and INV_VAR are copied into shadow registers that drive the outputs.
  - START → BUSY: unconditional.
  - BUSY → IDLE: on `done`. Sets DONE and latches CYCLES.
  - BUSY → IDLE: on ABORT. Sets neither DONE nor CYCLES.
  - BUSY → IDLE: on timeout. Sets TIMEOUT.
  - ABORT written in IDLE or START has no effect.
- Rejected launches set ERR and leave the state unchanged:
  - START written while not IDLE.
  - START written with EN = 0.
- When a single write sets both START and ABORT, ABORT takes priority and START is treated as not written.
- `start` is high only in START.
- Enables equal the shadow EN in START and BUSY, and are 0 in IDLE.
- `mean` and `inv_var` equal the shadow values at all times. Writes to MEAN or INV_VAR while BUSY update the register only; the outputs change at the next launch.
- `done` is sampled only in BUSY and is ignored in IDLE and START.
- Run counter:
  - Cleared on launch and increments every cycle in START and BUSY, saturating at 0xFFFF_FFFF.
  - CYCLES captures the count including the `done` cycle.
- When a W1C write and a hardware set of the same bit occur in one cycle, the set wins.
- Reset: state IDLE; all registers, shadows, STATUS and CYCLES are 0. All outputs are 0 except `PREADY` = 1. A reset mid-run abandons the run with no status recorded.

## Timing
- CTRL.START write committed in cycle T: `start` = 1 and enables valid in T+1; BUSY in T+2.
- `done` in cycle D while BUSY: enables are 0, STATUS.DONE = 1 and BUSY = 0 in D+1.
- Minimum CYCLES is 2 (`done` in the first BUSY cycle).
- A register write becomes visible to reads in the next cycle.
- Back-to-back runs: a new START may be written in the cycle after returning to IDLE.

## Configuration
- `CFG_SEQ_TIMEOUT_EN` defined:
  - A watchdog compares the run counter against TMO_LIMIT while BUSY.
  - If TMO_LIMIT ≠ 0 and the counter reaches TMO_LIMIT, the FSM goes to IDLE in the next cycle and sets STATUS.TIMEOUT. Enables go to 0 and CYCLES is not updated.
  - If `done` arrives in the same cycle the counter reaches the limit, `done` wins.
- Not defined: TMO_LIMIT reads 0 and writes are ignored; STATUS.TIMEOUT is always 0; no watchdog logic is built.

## Test plan
- Reset, then read every register → all 0 except as mapped; all outputs 0, `PREADY` = 1.
- Write MEAN = 0x12, INV_VAR = 0x34, CTRL = 0x13 (START, matmul + pool), then `done` 5 cycles after `start` → `start` is a one-cycle pulse; enables = {pool=1, matmul=1} until `done`+1; STATUS = 0x2; CYCLES = 6.
- During BUSY, write CTRL.START and write MEAN = 0x99 → STATUS.ERR = 1; run unaffected; `mean` stays 0x12 until the next launch.
- CTRL = 0x01 (EN = 0) → ERR = 1, no `start`, state stays IDLE. Then write CTRL = 0x100 while BUSY → IDLE; DONE = 0; CYCLES unchanged.
- `done` pulsed in IDLE and in the START cycle → ignored. Write STATUS = 0xE while DONE is also being set in the same cycle → DONE reads 1.
- With `CFG_SEQ_TIMEOUT_EN`, TMO_LIMIT = 10 and no `done` → IDLE in the cycle after the counter reaches 10; TIMEOUT = 1. Without the macro, TMO_LIMIT reads 0 and the run waits indefinitely.
